// File: rtl/argmax_pkg.sv
// Shared types and elaboration checks for the argmax scan controller.
package argmax_pkg;

  // Controller states: waiting for start, streaming samples, presenting result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } argmax_state_t;

  localparam int unsigned DEF_BIT_WIDTH   = 8;
  localparam int unsigned DEF_NUM_INPUTS  = 10;
  localparam int unsigned DEF_INDEX_WIDTH = 4;

  // True when the index width can address every sample and a scan has at least two samples.
  function automatic bit idx_width_ok(input int unsigned iw, input int unsigned n);
    return (n >= 32'd2) && ((64'd1 << iw) >= 64'(n));
  endfunction

endpackage

// File: rtl/larger_index.sv
// Single signed comparator: returns the larger value and its index; ties keep input 2.
module larger_index
  import argmax_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int unsigned NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH
) (
  input  logic signed [BIT_WIDTH-1:0]   i_in1,
  input  logic        [INDEX_WIDTH-1:0] i_idx1,
  input  logic signed [BIT_WIDTH-1:0]   i_in2,
  input  logic        [INDEX_WIDTH-1:0] i_idx2,
  output logic signed [BIT_WIDTH-1:0]   o_val_c,
  output logic        [INDEX_WIDTH-1:0] o_idx_c
);

  if (!idx_width_ok(INDEX_WIDTH, NUM_INPUTS)) begin : g_param_check
    $error("larger_index: INDEX_WIDTH too small for NUM_INPUTS");
  end

  logic w_take1;

  // Strict signed greater-than; input 2 (the earlier index) wins on equality.
  assign w_take1 = (i_in1 > i_in2);

  // Select the winning value/index pair.
  always_comb begin
    o_val_c = i_in2;
    o_idx_c = i_idx2;
    if (w_take1) begin
      o_val_c = i_in1;
      o_idx_c = i_idx1;
    end
  end

endmodule

// File: rtl/argmax_scan.sv
// Sequential argmax: streams NUM_INPUTS signed samples through one comparator
// and reports the largest value and its 0-based position.
module argmax_scan
  import argmax_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int unsigned NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic signed [BIT_WIDTH-1:0]   in_data,
  output logic                          in_ready,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [BIT_WIDTH-1:0]   max_val,
  output logic        [INDEX_WIDTH-1:0] max_idx
);

  if (!idx_width_ok(INDEX_WIDTH, NUM_INPUTS)) begin : g_param_check
    $error("argmax_scan: INDEX_WIDTH too small for NUM_INPUTS");
  end

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);

  argmax_state_t                r_state;
  logic [INDEX_WIDTH-1:0]       r_cnt;
  logic signed [BIT_WIDTH-1:0]  r_best_val;
  logic [INDEX_WIDTH-1:0]       r_best_idx;
  logic signed [BIT_WIDTH-1:0]  r_max_val;
  logic [INDEX_WIDTH-1:0]       r_max_idx;
  logic                         r_in_ready;
  logic                         r_busy;
  logic                         r_out_valid;

  logic                         w_accept;
  logic                         w_first;
  logic signed [BIT_WIDTH-1:0]  w_cmp_val;
  logic [INDEX_WIDTH-1:0]       w_cmp_idx;

  // A sample is taken only while scanning and the producer presents one.
  assign w_accept = (r_state == SCAN) && r_in_ready && in_valid;
  assign w_first  = (r_cnt == '0);

  larger_index #(
    .BIT_WIDTH   (BIT_WIDTH),
    .NUM_INPUTS  (NUM_INPUTS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_larger_index (
    .i_in1   (in_data),
    .i_idx1  (r_cnt),
    .i_in2   (r_best_val),
    .i_idx2  (r_best_idx),
    .o_val_c (w_cmp_val),
    .o_idx_c (w_cmp_idx)
  );

  // Scan FSM with counter, running-best and registered result/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_max_val   <= '0;
      r_max_idx   <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      // Abort from any state; partial results are discarded.
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt      <= '0;
          r_best_val <= '0;
          r_best_idx <= '0;
          if (start) begin
            r_state    <= SCAN;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        SCAN: begin
          if (w_accept) begin
            // Sample 0 seeds the running best without a compare.
            if (w_first) begin
              r_best_val <= in_data;
              r_best_idx <= '0;
              r_max_val  <= in_data;
              r_max_idx  <= '0;
            end else begin
              r_best_val <= w_cmp_val;
              r_best_idx <= w_cmp_idx;
              r_max_val  <= w_cmp_val;
              r_max_idx  <= w_cmp_idx;
            end
            if (r_cnt == LAST_IDX) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + INDEX_WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign max_val   = r_max_val;
  assign max_idx   = r_max_idx;

endmodule

// File: tb/tb_argmax_scan.sv
// Directed self-checking bench for argmax_scan (default parameters: 8-bit, 10 samples, 4-bit index).
module tb_argmax_scan;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              clear;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic              in_ready;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] max_val;
  logic [3:0]        max_idx;

  int n_vec;
  int n_err;
  int vec [10];
  int edges;

  argmax_scan dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max_val   (max_val),
    .max_idx   (max_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_max_val"},   32'(max_val),   0);
    chk({tag, "_max_idx"},   32'(max_idx),   0);
  endtask

  // Start a scan of vec[], optionally with one idle cycle before each sample; counts edges to out_valid.
  task automatic do_scan(input logic stall, output int n_edges);
    n_edges = 0;
    start = 1'b1;
    tick();
    n_edges++;
    start = 1'b0;
    chk("rdy_after_start", 32'(in_ready), 1);
    chk("busy_scan", 32'(busy), 1);
    for (int i = 0; i < 10; i++) begin
      if (stall) begin
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        n_edges++;
        chk("rdy_stall", 32'(in_ready), 1);
        chk("ov_stall", 32'(out_valid), 0);
      end
      in_valid = 1'b1;
      in_data  = 8'(vec[i]);
      tick();
      n_edges++;
    end
    in_valid = 1'b0;
    for (int g = 0; g < 20 && !out_valid; g++) begin
      tick();
      n_edges++;
    end
    chk("ov_rise", 32'(out_valid), 1);
  endtask

  task automatic finish_hold();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ov_drop", 32'(out_valid), 0);
    chk("busy_drop", 32'(busy), 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk_idle_zero("rst");
    rst_n = 1'b1;
    tick();
    chk_idle_zero("post_rst");

    // Basic scan: 7 appears at 2 and 6; first one kept. out_valid in cycle 12 counting the start cycle.
    vec = '{3, -5, 7, 1, 0, 2, 7, -128, 6, 4};
    do_scan(1'b0, edges);
    chk("basic_latency", 32'(edges), 11);
    chk("basic_val", 32'(max_val), 7);
    chk("basic_idx", 32'(max_idx), 2);
    chk("basic_rdy_hold", 32'(in_ready), 0);
    chk("basic_busy_hold", 32'(busy), 1);
    finish_hold();
    chk("basic_val_kept", 32'(max_val), 7);
    chk("basic_idx_kept", 32'(max_idx), 2);

    // All negative: -3 at 1 and 3, keep 1.
    vec = '{-10, -3, -128, -3, -50, -9, -4, -7, -8, -127};
    do_scan(1'b0, edges);
    chk("neg_val", 32'(max_val), -3);
    chk("neg_idx", 32'(max_idx), 1);
    finish_hold();

    // Max in last slot with in_valid toggling.
    vec = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 127};
    do_scan(1'b1, edges);
    chk("stall_latency", 32'(edges), 21);
    chk("stall_val", 32'(max_val), 127);
    chk("stall_idx", 32'(max_idx), 9);
    finish_hold();

    // Backpressure in HOLD with a start pulse that must be ignored.
    vec = '{1, 2, 3, -4, 50, 6, 50, 8, 9, 10};
    do_scan(1'b0, edges);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      tick();
      chk("bp_ov", 32'(out_valid), 1);
      chk("bp_val", 32'(max_val), 50);
      chk("bp_idx", 32'(max_idx), 4);
      chk("bp_rdy", 32'(in_ready), 0);
    end
    start = 1'b0;
    finish_hold();
    tick();
    chk("bp_no_start", 32'(in_ready), 0);

    // start together with clear in IDLE stays in IDLE.
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    chk("start_clear_rdy", 32'(in_ready), 0);
    chk("start_clear_busy", 32'(busy), 0);

    // Abort after 4 samples, then a full scan of 1..10.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_rdy", 32'(in_ready), 0);
    chk("abort_busy", 32'(busy), 0);
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("abort_no_ov", 32'(out_valid), 0);
    end
    vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    do_scan(1'b0, edges);
    chk("abort_latency", 32'(edges), 11);
    chk("abort_val", 32'(max_val), 10);
    chk("abort_idx", 32'(max_idx), 9);
    finish_hold();

    // Asynchronous reset mid-scan.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(20 + i);
      tick();
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_idle_zero("rst_scan");
    #1 rst_n = 1'b1;
    tick();
    chk_idle_zero("rst_scan_after");

    // Asynchronous reset in HOLD.
    vec = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    do_scan(1'b0, edges);
    chk("hold_val_pre_rst", 32'(max_val), 14);
    #1 rst_n = 1'b0;
    #1;
    chk_idle_zero("rst_hold");
    #1 rst_n = 1'b1;
    tick();
    chk_idle_zero("rst_hold_after");

    // Clean scan after reset.
    vec = '{-1, 2, 9, -7, 9, 3, 0, 8, -2, 1};
    do_scan(1'b0, edges);
    chk("clean_latency", 32'(edges), 11);
    chk("clean_val", 32'(max_val), 9);
    chk("clean_idx", 32'(max_idx), 2);
    finish_hold();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
